// File: rtl/pkt_field_builder_if.sv
// ----------------------------------------------------------------------------
// pkt_field_builder_if
//   Bundles the command handshake and the InBus-style beat bus of
//   pkt_field_builder.
//
//   Command side : Cmd_Valid, Cmd_Ready, Cmd_Length, Cmd_Fields, Cmd_Error
//   Beat side    : OutBus_Ready, OutBus_DataValid, OutBus_DataSop,
//                  OutBus_DataEop, OutBus_Mod, OutBus_Data
//
//   modport master : the builder's view (accepts commands, sources beats)
//   modport slave  : the view of the block feeding commands / sinking beats
// ----------------------------------------------------------------------------
interface pkt_field_builder_if #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned FIELD_NUMBER   = 4,
    parameter int unsigned FIELD_SIZE_MAX = 4
);
    localparam int unsigned MOD_WIDTH = $clog2(DATA_WIDTH / 8);

    logic                                     Cmd_Valid;
    logic                                     Cmd_Ready;
    logic [15:0]                              Cmd_Length;
    logic [FIELD_NUMBER*FIELD_SIZE_MAX*8-1:0] Cmd_Fields;
    logic                                     Cmd_Error;

    logic                                     OutBus_Ready;
    logic                                     OutBus_DataValid;
    logic                                     OutBus_DataSop;
    logic                                     OutBus_DataEop;
    logic [MOD_WIDTH-1:0]                     OutBus_Mod;
    logic [DATA_WIDTH-1:0]                    OutBus_Data;

    modport master (
        input  Cmd_Valid, Cmd_Length, Cmd_Fields, OutBus_Ready,
        output Cmd_Ready, Cmd_Error,
        output OutBus_DataValid, OutBus_DataSop, OutBus_DataEop,
        output OutBus_Mod, OutBus_Data
    );

    modport slave (
        output Cmd_Valid, Cmd_Length, Cmd_Fields, OutBus_Ready,
        input  Cmd_Ready, Cmd_Error,
        input  OutBus_DataValid, OutBus_DataSop, OutBus_DataEop,
        input  OutBus_Mod, OutBus_Data
    );
endinterface

// File: rtl/pkt_field_builder.sv
// ----------------------------------------------------------------------------
// pkt_field_builder
//   Packet source for the InBus beat protocol. Takes one command per packet
//   (length + one value per field), writes every field at its configured byte
//   offset, fills the remaining bytes and streams the packet out in
//   DATA_WIDTH-bit beats with SOP/EOP/Mod framing and full backpressure.
//
// Ports
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset
//   bus  : pkt_field_builder_if.master
//            Cmd_Valid/Cmd_Ready/Cmd_Length/Cmd_Fields  command handshake
//            Cmd_Error     one-cycle pulse after a rejected command
//            OutBus_*      beat stream (Ready in, Valid/Sop/Eop/Mod/Data out)
//
// Build option
//   PKT_BUILDER_LFSR_FILL_EN : filler bytes come from a 32-bit Fibonacci LFSR
//   (x^32+x^22+x^2+x+1, seed 32'hACE1_0001) stepped once per filler byte and
//   kept running across packets. Undefined: filler at packet index k is k[7:0].
// ----------------------------------------------------------------------------
module pkt_field_builder #(
    parameter int unsigned                     DATA_WIDTH     = 64,
    parameter int unsigned                     FIELD_NUMBER   = 4,
    parameter int unsigned                     FIELD_SIZE_MAX = 4,
    parameter logic [8*FIELD_NUMBER-1:0]       FIELD_OFFSET   = {8'd1, 8'd2, 8'd3, 8'd4},
    parameter logic [32*FIELD_NUMBER-1:0]      FIELD_SIZE     = {32'd1, 32'd2, 32'd3, 32'd4}
) (
    input logic                 Clk,
    input logic                 Rst,
    pkt_field_builder_if.master bus
);

    localparam int unsigned BPB          = DATA_WIDTH / 8;
    localparam int unsigned MOD_WIDTH    = $clog2(BPB);
    localparam int unsigned FIELD_BITS   = FIELD_SIZE_MAX * 8;
    localparam int unsigned FIELDS_WIDTH = FIELD_NUMBER * FIELD_BITS;

    // Shortest length that still holds every field completely.
    function automatic int unsigned calc_lmin();
        int unsigned m;
        int unsigned end_byte;
        m = 0;
        for (int unsigned i = 0; i < FIELD_NUMBER; i++) begin
            end_byte = 32'(FIELD_OFFSET[8*i +: 8]) + FIELD_SIZE[32*i +: 32];
            if (end_byte > m) m = end_byte;
        end
        return m;
    endfunction

    localparam int unsigned L_MIN = calc_lmin();

    // Returns {hit, byte} for packet byte k. Fields are scanned in ascending
    // index order so the highest overlapping field wins.
    function automatic logic [8:0] field_byte(input logic [31:0]             k,
                                              input logic [FIELDS_WIDTH-1:0] f);
        logic [8:0]  r;
        logic [31:0] off;
        logic [31:0] rel;
        r = '0;
        for (int unsigned i = 0; i < FIELD_NUMBER; i++) begin
            off = 32'(FIELD_OFFSET[8*i +: 8]);
            rel = k - off;
            if (k >= off && rel < FIELD_SIZE[32*i +: 32] && rel < FIELD_SIZE_MAX)
                r = {1'b1, f[FIELD_BITS*i + 8*rel +: 8]};
        end
        return r;
    endfunction

`ifdef PKT_BUILDER_LFSR_FILL_EN
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction
`endif

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_ready;
    logic                    r_err;
    logic                    r_valid;
    logic                    r_sop;
    logic                    r_eop;
    logic [MOD_WIDTH-1:0]    r_mod;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [15:0]             r_len;
    logic [FIELDS_WIDTH-1:0] r_fields;
    logic [15:0]             r_beat;
`ifdef PKT_BUILDER_LFSR_FILL_EN
    logic [31:0]             r_lfsr;
    logic [31:0]             w_lfsr_next;
`endif

    logic                    w_accept;
    logic                    w_cmd_ok;
    logic                    w_start;
    logic                    w_adv;

    logic [15:0]             w_src_len;
    logic [FIELDS_WIDTH-1:0] w_src_fields;
    logic [15:0]             w_src_beat;
    logic                    w_eop;
    logic [MOD_WIDTH-1:0]    w_mod;
    logic [DATA_WIDTH-1:0]   w_beat_data;

    // ------------------------------------------------------------------
    // FSM next state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = bus.Cmd_Valid && r_ready;
        w_cmd_ok     = (bus.Cmd_Length != 16'd0) && (32'(bus.Cmd_Length) >= L_MIN);
        w_start      = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_cmd_ok) begin
                    w_start      = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                w_adv = r_valid && bus.OutBus_Ready;
                if (w_adv && r_eop) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat composer. Beat 0 is built straight from the command inputs so it
    // can be registered on the accepting edge; later beats come from the
    // latched command.
    // ------------------------------------------------------------------
    always_comb begin : beat_compose
        logic [31:0] base;
        logic [31:0] k;
        logic [31:0] last_beat;
        logic [8:0]  hit;

        w_src_len    = r_len;
        w_src_fields = r_fields;
        w_src_beat   = r_beat + 16'd1;
        if (r_state == IDLE) begin
            w_src_len    = bus.Cmd_Length;
            w_src_fields = bus.Cmd_Fields;
            w_src_beat   = '0;
        end

        last_beat = (32'(w_src_len) - 32'd1) / BPB;
        w_eop     = (32'(w_src_beat) == last_beat);
        w_mod     = w_eop ? w_src_len[MOD_WIDTH-1:0] : '0;

        base        = 32'(w_src_beat) * BPB;
        k           = '0;
        hit         = '0;
        w_beat_data = '0;
`ifdef PKT_BUILDER_LFSR_FILL_EN
        w_lfsr_next = r_lfsr;
`endif
        for (int unsigned j = 0; j < BPB; j++) begin
            k   = base + j;
            hit = field_byte(k, w_src_fields);
            // Bytes past the packet end stay 0 and do not consume filler.
            if (k < 32'(w_src_len)) begin
                if (hit[8]) begin
                    w_beat_data[8*j +: 8] = hit[7:0];
                end else begin
`ifdef PKT_BUILDER_LFSR_FILL_EN
                    w_beat_data[8*j +: 8] = w_lfsr_next[7:0];
                    w_lfsr_next           = lfsr_step(w_lfsr_next);
`else
                    w_beat_data[8*j +: 8] = k[7:0];
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_mod    <= '0;
            r_data   <= '0;
            r_len    <= '0;
            r_fields <= '0;
            r_beat   <= '0;
`ifdef PKT_BUILDER_LFSR_FILL_EN
            r_lfsr   <= 32'hACE1_0001;
`endif
        end else begin
            r_state <= w_state_next;
            // Registered so it reads 0 in the cycle after reset is sampled.
            r_ready <= (w_state_next == IDLE);
            r_err   <= w_accept && !w_cmd_ok;

            if (w_start) begin
                r_len    <= bus.Cmd_Length;
                r_fields <= bus.Cmd_Fields;
            end

            if (w_start || (w_adv && !r_eop)) begin
                r_valid <= 1'b1;
                r_sop   <= w_start;
                r_eop   <= w_eop;
                r_mod   <= w_mod;
                r_data  <= w_beat_data;
                r_beat  <= w_src_beat;
`ifdef PKT_BUILDER_LFSR_FILL_EN
                r_lfsr  <= w_lfsr_next;
`endif
            end else if (w_adv) begin
                r_valid <= 1'b0;
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
                r_mod   <= '0;
                r_data  <= '0;
            end
        end
    end

    assign bus.Cmd_Ready        = r_ready;
    assign bus.Cmd_Error        = r_err;
    assign bus.OutBus_DataValid = r_valid;
    assign bus.OutBus_DataSop   = r_sop;
    assign bus.OutBus_DataEop   = r_eop;
    assign bus.OutBus_Mod       = r_mod;
    assign bus.OutBus_Data      = r_data;

endmodule

// File: tb/tb_pkt_field_builder.sv
// ----------------------------------------------------------------------------
// tb_pkt_field_builder
//   Directed + randomized bench for pkt_field_builder (default build: index
//   filler). Expected packets are painted into a byte array from the field
//   placement rules and then cut into beats.
// ----------------------------------------------------------------------------
module tb_pkt_field_builder;

    localparam int DW    = 64;
    localparam int FN    = 4;
    localparam int FSMAX = 4;
    localparam int BPB   = DW / 8;
    localparam int FW    = FN * FSMAX * 8;

    // Default placement: field i sits at byte OFF[i] and spans SZ[i] bytes.
    int OFF [FN] = '{4, 3, 2, 1};
    int SZ  [FN] = '{4, 3, 2, 1};

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]    exp_bytes [0:511];
    logic [DW-1:0] cap_data  [0:63];
    logic [DW-1:0] ref_data  [0:63];

    always #5 Clk = ~Clk;

    pkt_field_builder_if #(
        .DATA_WIDTH     (DW),
        .FIELD_NUMBER   (FN),
        .FIELD_SIZE_MAX (FSMAX)
    ) bus ();

    pkt_field_builder #(
        .DATA_WIDTH     (DW),
        .FIELD_NUMBER   (FN),
        .FIELD_SIZE_MAX (FSMAX),
        .FIELD_OFFSET   ({8'd1, 8'd2, 8'd3, 8'd4}),
        .FIELD_SIZE     ({32'd1, 32'd2, 32'd3, 32'd4})
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] out_all();
        return 128'({bus.Cmd_Ready, bus.Cmd_Error, bus.OutBus_DataValid, bus.OutBus_DataSop,
                     bus.OutBus_DataEop, bus.OutBus_Mod, bus.OutBus_Data});
    endfunction

    function automatic logic [127:0] obs_beat();
        return {59'b0, bus.OutBus_DataSop, bus.OutBus_DataEop, bus.OutBus_Mod, bus.OutBus_Data};
    endfunction

    function automatic logic [127:0] beat_state();
        return {58'b0, bus.OutBus_DataValid, bus.OutBus_DataSop, bus.OutBus_DataEop,
                bus.OutBus_Mod, bus.OutBus_Data};
    endfunction

    // Reference packet: index filler everywhere, then fields painted in
    // ascending order so a later field overwrites an earlier one.
    task automatic build_model(input int len, input logic [FW-1:0] f);
        for (int k = 0; k < len; k++) exp_bytes[k] = 8'(k);
        for (int i = 0; i < FN; i++)
            for (int j = 0; j < SZ[i]; j++)
                if (OFF[i] + j < len) exp_bytes[OFF[i] + j] = f[i*32 + j*8 +: 8];
    endtask

    function automatic logic [127:0] exp_beat(input int len, input int b);
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [2:0]    m;
        int            nb;
        nb  = (len + BPB - 1) / BPB;
        sop = (b == 0);
        eop = (b == nb - 1);
        m   = eop ? 3'(len % BPB) : 3'd0;
        d   = '0;
        for (int j = 0; j < BPB; j++)
            if (b*BPB + j < len) d[8*j +: 8] = exp_bytes[b*BPB + j];
        return {59'b0, sop, eop, m, d};
    endfunction

    task automatic run_packet(input int len, input logic [FW-1:0] f, input bit stall);
        int           nb;
        int           b;
        int           cycles;
        bit           hold;
        bit           rdy;
        logic [127:0] held;
        nb     = (len + BPB - 1) / BPB;
        b      = 0;
        cycles = 0;
        hold   = 0;
        held   = '0;
        build_model(len, f);

        check("cmd_ready_idle", 128'(bus.Cmd_Ready), 128'd1);
        bus.Cmd_Valid  = 1'b1;
        bus.Cmd_Length = 16'(len);
        bus.Cmd_Fields = f;
        tick();
        bus.Cmd_Valid  = 1'b0;
        bus.Cmd_Length = 16'($urandom);
        bus.Cmd_Fields = {$urandom, $urandom, $urandom, $urandom};
        check("first_beat_latency", 128'({bus.OutBus_DataValid, bus.OutBus_DataSop, bus.Cmd_Ready}),
              128'(3'b110));

        while (b < nb && cycles < 2000) begin
            if (hold) check("stall_hold", beat_state(), held);
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.OutBus_Ready = rdy;
            if (bus.OutBus_DataValid && rdy) begin
                check("beat", obs_beat(), exp_beat(len, b));
                cap_data[b] = bus.OutBus_Data;
                b++;
                hold = 0;
            end else if (bus.OutBus_DataValid) begin
                held = beat_state();
                hold = 1;
            end else begin
                hold = 0;
            end
            tick();
            cycles++;
        end
        check("beats_done", 128'(b), 128'(nb));
        if (!stall) check("no_bubbles", 128'(cycles), 128'(nb));
        check("eop_to_idle", 128'({bus.OutBus_DataValid, bus.Cmd_Ready}), 128'(2'b01));
    endtask

    task automatic reject(input int len);
        bus.OutBus_Ready = 1'($urandom);
        check("reject_ready", 128'(bus.Cmd_Ready), 128'd1);
        bus.Cmd_Valid  = 1'b1;
        bus.Cmd_Length = 16'(len);
        bus.Cmd_Fields = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus.Cmd_Valid = 1'b0;
        check("reject_pulse", 128'({bus.Cmd_Error, bus.Cmd_Ready, bus.OutBus_DataValid}), 128'(3'b110));
        for (int c = 0; c < 3; c++) begin
            bus.OutBus_Ready = ~bus.OutBus_Ready;
            tick();
            check("reject_after", 128'({bus.Cmd_Error, bus.Cmd_Ready, bus.OutBus_DataValid}),
                  128'(3'b010));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] f;
        int            lens [7];
        int            b;

        bus.Cmd_Valid    = 1'b0;
        bus.Cmd_Length   = '0;
        bus.Cmd_Fields   = '0;
        bus.OutBus_Ready = 1'b0;

        // Reset values, then ready on the first cycle out of reset.
        Rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", out_all(), '0);
        Rst = 1'b0;
        tick();
        check("ready_after_reset", 128'(bus.Cmd_Ready), 128'd1);

        // Minimum-length single-beat packet with overlapping fields.
        f = {32'h000000FF, 32'h0000EEDD, 32'h00CCBBAA, 32'h44332211};
        run_packet(8, f, 0);
        check("len8_data", 128'(cap_data[0]), 128'(64'h4433CCBBEEDDFF00));

        // Length 100, no stalls, then the same command under backpressure.
        f = {$urandom, $urandom, $urandom, $urandom};
        run_packet(100, f, 0);
        check("len100_last_lo", 128'(cap_data[12][31:0]), 128'(32'h63626160));
        check("len100_last_hi", 128'(cap_data[12][63:32]), 128'd0);
        for (int i = 0; i < 13; i++) ref_data[i] = cap_data[i];
        run_packet(100, f, 1);
        for (int i = 0; i < 13; i++) check("stall_vs_nostall", 128'(cap_data[i]), 128'(ref_data[i]));

        // Rejected commands: one short of the minimum, and zero.
        reject(7);
        reject(0);

        // Reset while beat 5 of a length-100 packet is on the bus.
        f = {$urandom, $urandom, $urandom, $urandom};
        build_model(100, f);
        bus.Cmd_Valid  = 1'b1;
        bus.Cmd_Length = 16'd100;
        bus.Cmd_Fields = f;
        tick();
        bus.Cmd_Valid    = 1'b0;
        bus.OutBus_Ready = 1'b1;
        for (b = 0; b < 5; b++) tick();
        check("pre_reset_beat5", obs_beat(), exp_beat(100, 5));
        Rst = 1'b1;
        tick();
        check("reset_mid_packet", out_all(), '0);
        tick();
        check("reset_held", out_all(), '0);
        Rst = 1'b0;
        tick();
        check("ready_after_reset2", 128'({bus.Cmd_Ready, bus.OutBus_DataValid}), 128'(2'b10));
        run_packet(16, {$urandom, $urandom, $urandom, $urandom}, 0);

        // Beat-boundary lengths.
        lens = '{9, 15, 16, 17, 24, 25, 64};
        foreach (lens[i]) run_packet(lens[i], {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));

        // Eight length-100 packets with random fields, back to back.
        for (int p = 0; p < 8; p++) run_packet(100, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));

        // Random lengths.
        for (int p = 0; p < 6; p++)
            run_packet($urandom_range(8, 200), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
